param_limit_counter: RTL



---
 rtl/param_limit_counter.sv | 81 ++++++++
 1 files changed

// File: rtl/param_limit_counter.sv
`default_nettype none
// ============================================================================
// Module  : param_limit_counter
// Brief   : Multi-channel wrap-around counter with a runtime-writable
//           per-channel limit, a wrap pulse and a saturating wrap counter.
// Revision: 1.0 - initial release
// ============================================================================
module param_limit_counter #(
    parameter int           CH    = 1,
    parameter int           W     = 5,
    parameter logic [W-1:0] LIMIT = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH-1:0]     en,
    input  logic [CH-1:0]     clr,
    input  logic              lim_we,
    input  logic [2:0]        lim_ch,
    input  logic [31:0]       lim_wdata,
    output logic [CH*32-1:0]  cnt,
    output logic [CH*32-1:0]  lim,
    output logic [CH-1:0]     wrap,
    output logic [CH*8-1:0]   wrap_cnt
);

    localparam logic [W-1:0] c_one      = W'(1);
    localparam logic [7:0]   c_wrap_max = 8'hFF;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [W-1:0] r_cnt;
        logic [W-1:0] r_lim;
        logic         r_wrap;
        logic [7:0]   r_wrap_cnt;
        logic         w_lim_sel;

        // Channel indices >= CH never match, so out-of-range writes are dropped.
        assign w_lim_sel = lim_we && (lim_ch == 3'(c));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt      <= '0;
                r_lim      <= LIMIT;
                r_wrap     <= 1'b0;
                r_wrap_cnt <= '0;
            end else begin
                if (w_lim_sel) begin
                    r_lim <= lim_wdata[W-1:0];
                end
                // Terminal test uses >= so a limit lowered under cnt wraps at once.
                if (clr[c]) begin
                    r_cnt      <= '0;
                    r_wrap     <= 1'b0;
                    r_wrap_cnt <= '0;
                end else if (en[c] && (r_cnt >= r_lim)) begin
                    r_cnt  <= '0;
                    r_wrap <= 1'b1;
                    if (r_wrap_cnt != c_wrap_max) begin
                        r_wrap_cnt <= r_wrap_cnt + 8'd1;
                    end
                end else if (en[c]) begin
                    r_cnt  <= r_cnt + c_one;
                    r_wrap <= 1'b0;
                end else begin
                    r_wrap <= 1'b0;
                end
            end
        end

        assign cnt[32*c +: 32]     = 32'(r_cnt);
        assign lim[32*c +: 32]     = 32'(r_lim);
        assign wrap[c]             = r_wrap;
        assign wrap_cnt[8*c +: 8]  = r_wrap_cnt;
    end

    if (W < 32) begin : g_unused_hi
        logic w_unused_hi;
        assign w_unused_hi = ^lim_wdata[31:W];
    end

endmodule
`default_nettype wire
